// File: rtl/ibex_loader_pkg.sv
// ibex_loader_pkg: shared types and constants for the ibex program loader.
//   core_state_e : HALT / RSTHOLD / RUN encoding (also reported in STATUS[1:0])
//   bus_state_e  : Wishbone slave FSM encoding
//   CSR offsets, CTRL bit indices and the STATUS word packing helper.
package ibex_loader_pkg;

  typedef logic [1:0] core_state_e;
  localparam core_state_e CoreHalt    = 2'd0;
  localparam core_state_e CoreRstHold = 2'd1;
  localparam core_state_e CoreRun     = 2'd2;

  typedef logic [1:0] bus_state_e;
  localparam bus_state_e BusIdle  = 2'd0;
  localparam bus_state_e BusMemRd = 2'd1;
  localparam bus_state_e BusAck   = 2'd2;

  localparam logic [15:0] CsrCtrlOff   = 16'h1000;
  localparam logic [15:0] CsrStatusOff = 16'h1004;

  localparam int unsigned CtrlStartBit  = 0;
  localparam int unsigned CtrlHaltBit   = 1;
  localparam int unsigned CtrlClrErrBit = 2;

  function automatic logic [31:0] status_word(input logic [15:0] core_status,
                                              input logic [7:0]  ext_sync,
                                              input logic        err,
                                              input core_state_e st);
    return {core_status, ext_sync, 5'b0, err, st};
  endfunction

endpackage

// File: rtl/ibex_prog_loader_sync_edge_det.sv
// sync_edge_det: SYNC_STG-flop synchroniser for one asynchronous input plus a
// rising-edge detector on the synchronised level.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (chain and edge history cleared)
//   d_i     : asynchronous input
//   level_o : synchronised level
//   rise_o  : one-cycle pulse on a synchronised 0->1 transition
module sync_edge_det #(
  parameter int unsigned SYNC_STG = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STG-1:0] chain_q;
  logic                prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STG-2:0], d_i};
      prev_q  <= chain_q[SYNC_STG-1];
    end
  end

  // A held-high input yields one pulse; a low must pass the chain to re-arm.
  assign level_o = chain_q[SYNC_STG-1];
  assign rise_o  = chain_q[SYNC_STG-1] & ~prev_q;

endmodule

// File: rtl/ibex_prog_loader.sv
// ibex_prog_loader: Wishbone slave that lets firmware load the ibex IMEM word by
// word, and sequences the core's reset release and fetch enable.
//   wb_clk_i/wb_rst_i   : clock, synchronous active-high reset
//   wbs_*               : Wishbone slave (single-cycle ack, read data valid with ack)
//   mem_*               : IMEM port; read data returns one cycle after mem_en_o
//   ext_ctrl_i          : async pads; bit5 is a start request, all bits in STATUS
//   ibex_status_i       : core checkpoint value, shown in STATUS[31:16]
//   ibex_rst_n_o        : ibex reset (active-low), fetch_en_o : ibex fetch enable
// Map: 0x0000-0x0FFF IMEM, 0x1000 CTRL (wr: bit0 start, bit1 halt, bit2 clr_err),
//      0x1004 STATUS (rd), everything else reads 0 / ignores writes.
module ibex_prog_loader
  import ibex_loader_pkg::*;
#(
  parameter int unsigned MEM_AW    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned SYNC_STG  = 2,
  parameter int unsigned RST_HOLD  = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic [7:0]        ext_ctrl_i,
  input  logic [15:0]       ibex_status_i,
  output logic              ibex_rst_n_o,
  output logic              fetch_en_o
);

  core_state_e core_q, core_d;
  bus_state_e  bus_q, bus_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;

  // Start pin gets edge detection; the other seven bits are only observed.
  logic [SYNC_STG-1:0][6:0] ext_q;
  logic                     start_level, start_rise;
  logic [7:0]               ext_sync;

  sync_edge_det #(
    .SYNC_STG(SYNC_STG)
  ) u_start_sync (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .d_i    (ext_ctrl_i[5]),
    .level_o(start_level),
    .rise_o (start_rise)
  );

  assign ext_sync = {ext_q[SYNC_STG-1][6:5], start_level, ext_q[SYNC_STG-1][4:0]};

  logic req, idle_req, in_imem, is_status, imem_wr, ctrl_wr;
  logic halt_req, start_req, clr_err;

  always_comb begin
    // Reset gates the request so nothing is launched while wb_rst_i is high.
    req       = wbs_cyc_i & wbs_stb_i & ~wb_rst_i & (wbs_adr_i[31:16] == BASE_ADDR[31:16]);
    idle_req  = req & (bus_q == BusIdle);
    in_imem   = (wbs_adr_i[15:12] == 4'h0);
    is_status = (wbs_adr_i[15:0] == CsrStatusOff);
    imem_wr   = idle_req & in_imem & wbs_we_i;
    ctrl_wr   = idle_req & wbs_we_i & wbs_sel_i[0] & (wbs_adr_i[15:0] == CsrCtrlOff);
    halt_req  = ctrl_wr & wbs_dat_i[CtrlHaltBit];
    start_req = (ctrl_wr & wbs_dat_i[CtrlStartBit]) | start_rise;
    clr_err   = ctrl_wr & wbs_dat_i[CtrlClrErrBit];
  end

  // IMEM port is driven combinationally in the IDLE cycle of the request.
  assign mem_en_o    = idle_req & in_imem;
  assign mem_we_o    = (imem_wr && core_q == CoreHalt) ? wbs_sel_i : 4'h0;
  assign mem_addr_o  = wbs_adr_i[MEM_AW+1:2];
  assign mem_wdata_o = wbs_dat_i;

  // Ack only while the master still strobes; a dropped request finishes silently.
  assign wbs_ack_o = (bus_q == BusAck) & wbs_cyc_i & wbs_stb_i;
  assign wbs_dat_o = dat_q;

  assign ibex_rst_n_o = (core_q == CoreRun);
  assign fetch_en_o   = (core_q == CoreRun);

  always_comb begin
    bus_d = bus_q;
    dat_d = dat_q;
    unique case (bus_q)
      BusIdle: begin
        if (idle_req) begin
          if (in_imem && !wbs_we_i) begin
            bus_d = BusMemRd;
          end else begin
            bus_d = BusAck;
            dat_d = (!wbs_we_i && is_status) ?
                    status_word(ibex_status_i, ext_sync, err_q, core_q) : 32'h0;
          end
        end
      end
      BusMemRd: begin
        bus_d = BusAck;
        dat_d = mem_rdata_i;
      end
      BusAck: begin
        bus_d = BusIdle;
        dat_d = 32'h0;
      end
      default: bus_d = BusIdle;
    endcase
  end

  always_comb begin
    core_d = core_q;
    cnt_d  = cnt_q;
    if (halt_req) begin
      core_d = CoreHalt;
    end else begin
      unique case (core_q)
        CoreHalt: begin
          if (start_req) begin
            core_d = CoreRstHold;
            cnt_d  = RST_HOLD[3:0];
          end
        end
        CoreRstHold: begin
          // Leave when the counter would reach zero: exactly RST_HOLD cycles here.
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) core_d = CoreRun;
        end
        CoreRun:  ;
        default:  core_d = CoreHalt;
      endcase
    end
  end

  always_comb begin
    err_d = err_q;
    if (clr_err) begin
      err_d = 1'b0;
    end else if (imem_wr && core_q != CoreHalt) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      core_q <= CoreHalt;
      bus_q  <= BusIdle;
      cnt_q  <= 4'h0;
      err_q  <= 1'b0;
      dat_q  <= 32'h0;
      ext_q  <= '0;
    end else begin
      core_q <= core_d;
      bus_q  <= bus_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      dat_q  <= dat_d;
      ext_q  <= {ext_q[SYNC_STG-2:0], ext_ctrl_i[7:6], ext_ctrl_i[4:0]};
    end
  end

endmodule

// File: tb/tb_ibex_prog_loader.sv
module tb_ibex_prog_loader;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [7:0]  ext_ctrl = 8'h00;
  logic [15:0] ibex_status = 16'hA5C3;
  logic        ibex_rst_n, fetch_en;

  int n_vec = 0;
  int n_fail = 0;

  always #5 wb_clk = ~wb_clk;

  ibex_prog_loader #(
    .MEM_AW   (10),
    .BASE_ADDR(32'h3000_0000),
    .SYNC_STG (2),
    .RST_HOLD (4)
  ) dut (
    .wb_clk_i     (wb_clk),
    .wb_rst_i     (wb_rst),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (wdat),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (rdat),
    .mem_en_o     (mem_en),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .ext_ctrl_i   (ext_ctrl),
    .ibex_status_i(ibex_status),
    .ibex_rst_n_o (ibex_rst_n),
    .fetch_en_o   (fetch_en)
  );

  // Synchronous-read SRAM standing in for the ibex IMEM.
  logic [31:0] sram [1024] = '{default: 32'h0};
  always @(posedge wb_clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= sram[mem_addr];
    end
  end

  logic [31:0] ref_mem [1024] = '{default: 32'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One Wishbone transfer; lat counts cycles from the request cycle to the ack.
  task automatic wb_xfer(input logic w_en, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic got, output int lat,
                         output logic [31:0] rd, output logic [3:0] we0,
                         output logic [9:0] addr0);
    @(posedge wb_clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w_en; adr = a; sel = s; wdat = d;
    got = 1'b0; lat = -1; rd = 32'h0; we0 = 4'h0; addr0 = 10'h0;
    for (int c = 0; c < 6; c++) begin
      @(negedge wb_clk);
      if (c == 0) begin
        we0 = mem_we;
        addr0 = mem_addr;
      end
      if (ack) begin
        got = 1'b1;
        lat = c;
        rd = rdat;
        break;
      end
    end
    @(posedge wb_clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic count_until_run(output int n);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge wb_clk);
      if (ibex_rst_n) break;
      n++;
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int c = 0; c < n; c++) @(posedge wb_clk);
    #1;
  endtask

  typedef struct {
    logic        w_en;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp_rd;
    int          exp_lat;
    logic        exp_ack;
    string       name;
  } vec_t;

  vec_t vecs [14];

  logic        got;
  int          lat, n, acks;
  logic [31:0] rd;
  logic [3:0]  we0;
  logic [9:0]  a0;
  logic        halted_m, err_m;

  initial begin
    vecs[0]  = '{1'b1, 32'h3000_0014, 4'h3, 32'h1234_5678, 32'h0, 1, 1'b1, "imem_wr_lo"};
    vecs[1]  = '{1'b0, 32'h3000_0014, 4'hF, 32'h0, 32'h0000_5678, 2, 1'b1, "imem_rd_lo"};
    vecs[2]  = '{1'b1, 32'h3000_0014, 4'hC, 32'hAABB_CCDD, 32'h0, 1, 1'b1, "imem_wr_hi"};
    vecs[3]  = '{1'b0, 32'h3000_0014, 4'hF, 32'h0, 32'hAABB_5678, 2, 1'b1, "imem_rd_merge"};
    vecs[4]  = '{1'b1, 32'h3000_0FFC, 4'hF, 32'hCAFE_F00D, 32'h0, 1, 1'b1, "imem_wr_top"};
    vecs[5]  = '{1'b0, 32'h3000_0FFC, 4'hF, 32'h0, 32'hCAFE_F00D, 2, 1'b1, "imem_rd_top"};
    vecs[6]  = '{1'b0, 32'h3000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 2, 1'b1, "imem_rd_10"};
    vecs[7]  = '{1'b0, 32'h3000_1004, 4'hF, 32'h0, 32'hA5C3_0000, 1, 1'b1, "status_halt"};
    vecs[8]  = '{1'b0, 32'h3000_1000, 4'hF, 32'h0, 32'h0, 1, 1'b1, "ctrl_rd"};
    vecs[9]  = '{1'b1, 32'h3000_2000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1, 1'b1, "hole_wr"};
    vecs[10] = '{1'b0, 32'h3000_2000, 4'hF, 32'h0, 32'h0, 1, 1'b1, "hole_rd"};
    vecs[11] = '{1'b0, 32'h3001_0010, 4'hF, 32'h0, 32'h0, 0, 1'b0, "off_base"};
    vecs[12] = '{1'b1, 32'h3000_1000, 4'hE, 32'h1, 32'h0, 1, 1'b1, "ctrl_no_lane0"};
    vecs[13] = '{1'b0, 32'h3000_1004, 4'hF, 32'h0, 32'hA5C3_0000, 1, 1'b1, "status_still_halt"};

    wait_cycles(3);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    chk("rst_ack", {31'b0, ack}, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_mem_en", {31'b0, mem_en}, 0);
    chk("rst_mem_we", {28'b0, mem_we}, 0);
    chk("rst_rst_n", {31'b0, ibex_rst_n}, 0);
    chk("rst_fetch_en", {31'b0, fetch_en}, 0);

    wb_xfer(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, got, lat, rd, we0, a0);
    chk("wr10_mem_we", {28'b0, we0}, 32'hF);
    chk("wr10_addr", {22'b0, a0}, 4);
    chk("wr10_ack", {31'b0, got}, 1);
    chk("wr10_lat", lat, 1);

    for (int i = 0; i < 14; i++) begin
      wb_xfer(vecs[i].w_en, vecs[i].a, vecs[i].s, vecs[i].d, got, lat, rd, we0, a0);
      chk({vecs[i].name, "_ack"}, {31'b0, got}, {31'b0, vecs[i].exp_ack});
      if (vecs[i].exp_ack) chk({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
      if (vecs[i].exp_ack && !vecs[i].w_en) chk({vecs[i].name, "_data"}, rd, vecs[i].exp_rd);
    end

    // CTRL start: reset must stay low exactly four cycles after the request.
    @(posedge wb_clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_1000; sel = 4'h1; wdat = 32'h1;
    @(posedge wb_clk);
    n = 0; acks = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge wb_clk);
      if (ack) begin
        acks++;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
      end
      if (ibex_rst_n) break;
      n++;
    end
    chk("start_rst_low_cycles", n, 4);
    chk("start_ack_count", acks, 1);
    chk("start_fetch_en", {31'b0, fetch_en}, 1);
    wb_xfer(1'b0, 32'h3000_1004, 4'hF, 32'h0, got, lat, rd, we0, a0);
    chk("status_run", rd, 32'hA5C3_0002);

    wb_xfer(1'b1, 32'h3000_1000, 4'h1, 32'h1, got, lat, rd, we0, a0);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge wb_clk);
      if (!ibex_rst_n) n++;
    end
    chk("restart_ignored", n, 0);

    wb_xfer(1'b1, 32'h3000_1000, 4'h1, 32'h2, got, lat, rd, we0, a0);
    @(negedge wb_clk);
    chk("halt_rst_n", {31'b0, ibex_rst_n}, 0);

    // External start pin, asserted away from the clock edge.
    @(posedge wb_clk); #3;
    ext_ctrl = 8'h26;
    count_until_run(n);
    chk("ext_start_window", {31'b0, (n >= 6 && n <= 8)}, 1);
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge wb_clk);
      if (!ibex_rst_n) n++;
    end
    chk("ext_held_single_run", n, 0);
    wb_xfer(1'b0, 32'h3000_1004, 4'hF, 32'h0, got, lat, rd, we0, a0);
    chk("status_ext_run", rd, 32'hA5C3_2602);

    wb_xfer(1'b1, 32'h3000_1000, 4'h1, 32'h2, got, lat, rd, we0, a0);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge wb_clk);
      if (!ibex_rst_n) n++;
    end
    chk("ext_held_no_rearm", n, 10);

    ext_ctrl = 8'h06;
    wait_cycles(5);
    #2;
    ext_ctrl = 8'h26;
    count_until_run(n);
    chk("ext_rearm_window", {31'b0, (n >= 6 && n <= 8)}, 1);

    // IMEM write while running is acked but suppressed and flagged.
    wb_xfer(1'b1, 32'h3000_0010, 4'hF, 32'h1111_1111, got, lat, rd, we0, a0);
    chk("run_wr_ack", {31'b0, got}, 1);
    chk("run_wr_no_we", {28'b0, we0}, 0);
    wb_xfer(1'b0, 32'h3000_1004, 4'hF, 32'h0, got, lat, rd, we0, a0);
    chk("status_err", rd, 32'hA5C3_2606);
    wb_xfer(1'b1, 32'h3000_1000, 4'h1, 32'h6, got, lat, rd, we0, a0);
    wb_xfer(1'b0, 32'h3000_1004, 4'hF, 32'h0, got, lat, rd, we0, a0);
    chk("status_halt_clr", rd, 32'hA5C3_2600);
    wb_xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, got, lat, rd, we0, a0);
    chk("imem_unchanged", rd, 32'hDEAD_BEEF);
    ext_ctrl = 8'h00;
    wait_cycles(4);

    // Bus reset landing while an IMEM read sits in MEMRD.
    wb_xfer(1'b1, 32'h3000_1000, 4'h1, 32'h1, got, lat, rd, we0, a0);
    wait_cycles(8);
    wb_xfer(1'b1, 32'h3000_0020, 4'hF, 32'h5555_5555, got, lat, rd, we0, a0);
    @(posedge wb_clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0010; sel = 4'hF;
    @(posedge wb_clk); #1;
    chk("memrd_no_ack", {31'b0, ack}, 0);
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;
    chk("wbrst_ack", {31'b0, ack}, 0);
    chk("wbrst_dat", rdat, 0);
    chk("wbrst_mem_en", {31'b0, mem_en}, 0);
    chk("wbrst_mem_we", {28'b0, mem_we}, 0);
    chk("wbrst_rst_n", {31'b0, ibex_rst_n}, 0);
    chk("wbrst_fetch_en", {31'b0, fetch_en}, 0);
    cyc = 1'b0; stb = 1'b0; wb_rst = 1'b0;
    wb_xfer(1'b0, 32'h3000_1004, 4'hF, 32'h0, got, lat, rd, we0, a0);
    chk("status_after_wbrst", rd, 32'hA5C3_0000);

    // Randomised traffic against a lane-level memory and core-mode model.
    halted_m = 1'b1;
    err_m = 1'b0;
    for (int i = 0; i < 300; i++) begin
      int          op, w;
      logic [31:0] a, d;
      logic [3:0]  s;
      op = $urandom_range(0, 9);
      w  = $urandom_range(128, 191);
      a  = 32'h3000_0000 + 32'(w) * 4;
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      if (op == 0) begin
        d = 32'($urandom_range(0, 7));
        wb_xfer(1'b1, 32'h3000_1000, s, d, got, lat, rd, we0, a0);
        chk("rnd_ctrl_ack", {31'b0, got}, 1);
        if (s[0]) begin
          if (d[1]) halted_m = 1'b1;
          else if (d[0]) halted_m = 1'b0;
          if (d[2]) err_m = 1'b0;
        end
      end else if (op == 1) begin
        wb_xfer(1'b0, 32'h3000_1004, 4'hF, 32'h0, got, lat, rd, we0, a0);
        chk("rnd_status_hi", {2'b0, rd[31:2]}, {2'b0, 16'hA5C3, 8'h00, 5'b0, err_m});
        chk("rnd_status_halted", {31'b0, rd[1:0] == 2'b00}, {31'b0, halted_m});
      end else if (op <= 5) begin
        wb_xfer(1'b1, a, s, d, got, lat, rd, we0, a0);
        chk("rnd_wr_lat", got ? lat : -1, 1);
        chk("rnd_wr_we", {28'b0, we0}, halted_m ? {28'b0, s} : 32'h0);
        if (halted_m) begin
          for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
        end else begin
          err_m = 1'b1;
        end
      end else begin
        wb_xfer(1'b0, a, 4'hF, 32'h0, got, lat, rd, we0, a0);
        chk("rnd_rd_lat", got ? lat : -1, 2);
        chk("rnd_rd_data", rd, ref_mem[w]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
